window_feeder: RTL and testbench
================================

WINDOW_FEEDER -- requirements
Module: window_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width and height in pixels.
REQ-002 SHALL have parameter K, default 5, window edge; windows per axis = IMG_W-K+1 = 24.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 PIX_IN  input  8  pixel byte, raster order (row-major, index = row*28+col).
REQ-006 PIX_VALID  input  1  PIX_IN valid this cycle.
REQ-007 PIX_READY  output  1  block accepts PIX_IN; transfer when PIX_VALID & PIX_READY at rising edge.
REQ-008 START  output  1  one-cycle pulse marking first window of each frame to simpleCNN.
REQ-009 X  output  5  window top row, 0..23.
REQ-010 Y  output  5  window left column, 0..23.
REQ-011 IMGIN  output  200  5x5 window; IMGIN[(i*5+j)*8 +: 8] = pixel[(X+i)*28 + (Y+j)], i,j in 0..4.
REQ-012 WIN_VALID  output  1  IMGIN/X/Y hold a complete window.
REQ-013 WIN_READY  input  1  downstream consumes window; transfer when WIN_VALID & WIN_READY at rising edge.
REQ-014 FRAME_DONE  output  1  one-cycle pulse after last window (23,23) of a frame is consumed.

Function
REQ-015 SHALL store one frame in a 784 x 8 internal buffer; buffer contents not reset.
REQ-016 FSM states: LOAD, GATHER, PRESENT; reset state LOAD.
REQ-017 LOAD: PIX_READY=1; each accepted byte written at address pixel counter (0..783), counter +1; cycles without PIX_VALID do not advance.
REQ-018 LOAD -> GATHER on the edge accepting byte 783; pixel counter -> 0, X=Y=0.
REQ-019 PIX_READY SHALL be 0 in GATHER and PRESENT; PIX_VALID there ignored, no buffer write.
REQ-020 GATHER: tap counter 0..24, one tap per cycle, tap t=i*5+j writes IMGIN byte t from buffer[(X+i)*28+(Y+j)]; exactly 25 cycles.
REQ-021 GATHER -> PRESENT after tap 24; WIN_VALID=1 from the next cycle, i.e. first WIN_VALID cycle is 25 cycles after GATHER entry.
REQ-022 PRESENT: WIN_VALID, IMGIN, X, Y held stable until accepted; WIN_READY ignored outside PRESENT.
REQ-023 START SHALL be high only in the first PRESENT cycle of window (0,0); not re-asserted while that window is stalled.
REQ-024 On acceptance, WIN_VALID drops next cycle; Y+1; if Y was 23 then Y=0, X+1; then GATHER.
REQ-025 On acceptance of (23,23): X=Y=0, FRAME_DONE=1 for exactly one cycle, state -> LOAD, PIX_READY=1 next cycle.
REQ-026 Exactly 576 windows per frame, in order Y fastest, X slowest.
REQ-027 No arithmetic wrap: X, Y never exceed 23; pixel address max 783.

Reset
REQ-028 nRST low SHALL immediately set: state LOAD, PIX_READY=1 (after release), WIN_VALID=0, START=0, FRAME_DONE=0, X=0, Y=0, IMGIN=0, pixel and tap counters 0.
REQ-029 Reset mid-LOAD/GATHER/PRESENT SHALL abandon the frame; next frame reloads from address 0.

Verification
REQ-030 Reset: nRST low 2 cycles -> all outputs per REQ-028, PIX_READY=1 first cycle after release.
REQ-031 Ramp load pixel[k]=k mod 256, PIX_VALID gapped every 3rd cycle -> only accepted bytes counted; 25 cycles after byte 783 WIN_VALID=1, START=1 one cycle, X=0,Y=0, IMGIN bytes 0/4/5/24 = 0x00/0x04/0x1C/0x74.
REQ-032 Backpressure: WIN_READY low 10 cycles on window (0,0) -> IMGIN, X, Y stable, START not repeated; WIN_READY high 1 cycle -> next window X=0,Y=1, byte0=0x01, 25 cycles later.
REQ-033 Row wrap: accept (0,23) -> next window X=1,Y=0, byte0=0x1C, byte24=0x90.
REQ-034 Frame end: window (23,23) byte24=0x0F; on acceptance FRAME_DONE one cycle, PIX_READY=1, 576 windows counted total.
REQ-035 Reset asserted mid-GATHER of window (5,7) -> WIN_VALID=0, X=Y=0 immediately; fresh load of 784 bytes yields window (0,0) of new frame.

Source files
------------

// File: rtl/window_feeder.sv
// window_feeder: buffers one raster-order 28x28 frame of 8-bit pixels, then
// walks every 5x5 window (column index fastest, row index slowest) and hands
// each one downstream over a valid/ready handshake.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   pix_in     pixel byte, raster order
//   pix_valid  pix_in valid this cycle
//   pix_ready  block is loading; a byte transfers when pix_valid & pix_ready
//   start      one-cycle pulse on the first presentation of window (0,0)
//   x          window top row
//   y          window left column
//   imgin      window bytes; byte (i*K+j) = pixel[(x+i)*IMG_W + (y+j)]
//   win_valid  imgin/x/y hold a complete window
//   win_ready  downstream consumes the window
//   frame_done one-cycle pulse after the last window of a frame is consumed
//
// state   | meaning
// LOAD    | accepting pixels into the frame buffer
// GATHER  | copying one tap per cycle from the buffer into imgin
// PRESENT | window held on the outputs until consumed
module window_feeder #(
    parameter int IMG_W = 28,
    parameter int K     = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [7:0]                         pix_in,
    input  logic                               pix_valid,
    output logic                               pix_ready,
    output logic                               start,
    output logic [$clog2(IMG_W-K+1)-1:0]       x,
    output logic [$clog2(IMG_W-K+1)-1:0]       y,
    output logic [K*K*8-1:0]                   imgin,
    output logic                               win_valid,
    input  logic                               win_ready,
    output logic                               frame_done
);

    localparam int XW   = $clog2(IMG_W - K + 1);
    localparam int NPIX = IMG_W * IMG_W;
    localparam int AW   = $clog2(NPIX);
    localparam int NTAP = K * K;
    localparam int TW   = $clog2(NTAP);
    localparam int OW   = $clog2(K);

    localparam logic [XW-1:0] LAST_POS = XW'(IMG_W - K);
    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
    localparam logic [TW-1:0] LAST_TAP = TW'(NTAP - 1);
    localparam logic [OW-1:0] LAST_OFF = OW'(K - 1);

    typedef enum logic [1:0] {LOAD, GATHER, PRESENT} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [NPIX];
    logic [AW-1:0]   pix_cnt;
    logic [AW-1:0]   rd_addr;
    logic [TW-1:0]   tap;
    logic [OW-1:0]   row_off;
    logic [OW-1:0]   col_off;
    logic            load_last;
    logic            gather_last;
    logic            win_take;
    logic            frame_last;

    assign pix_ready   = (state == LOAD);
    assign win_valid   = (state == PRESENT);
    assign load_last   = pix_ready && pix_valid && (pix_cnt == LAST_PIX);
    assign gather_last = (state == GATHER) && (tap == LAST_TAP);
    assign win_take    = win_valid && win_ready;
    assign frame_last  = win_take && (x == LAST_POS) && (y == LAST_POS);

    // row/col offsets track the tap so no divide-by-K is needed for the address
    assign rd_addr = (AW'(x) + AW'(row_off)) * AW'(IMG_W) + AW'(y) + AW'(col_off);

    // frame buffer is deliberately not reset
    always_ff @(posedge clk) begin
        if (pix_ready && pix_valid) begin
            mem[pix_cnt] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (load_last) state_nxt = GATHER;
            GATHER:  if (gather_last) state_nxt = PRESENT;
            PRESENT: begin
                if (frame_last) begin
                    state_nxt = LOAD;
                end else if (win_take) begin
                    state_nxt = GATHER;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt    <= '0;
            tap        <= '0;
            row_off    <= '0;
            col_off    <= '0;
            x          <= '0;
            y          <= '0;
            imgin      <= '0;
            start      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // start fires only on the GATHER->PRESENT edge of window (0,0),
            // so a stalled first window never repeats it
            start      <= gather_last && (x == '0) && (y == '0);
            frame_done <= frame_last;
            case (state)
                LOAD: begin
                    if (pix_valid) begin
                        if (load_last) begin
                            pix_cnt <= '0;
                            x       <= '0;
                            y       <= '0;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                GATHER: begin
                    imgin[int'(tap)*8 +: 8] <= mem[rd_addr];
                    if (gather_last) begin
                        tap     <= '0;
                        row_off <= '0;
                        col_off <= '0;
                    end else begin
                        tap <= tap + 1'b1;
                        if (col_off == LAST_OFF) begin
                            col_off <= '0;
                            row_off <= row_off + 1'b1;
                        end else begin
                            col_off <= col_off + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (win_take) begin
                        if (y == LAST_POS) begin
                            y <= '0;
                            if (x == LAST_POS) begin
                                x <= '0;
                            end else begin
                                x <= x + 1'b1;
                            end
                        end else begin
                            y <= y + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
// Bench for window_feeder: directed frames plus a per-cycle reference model
// that rebuilds every expected window from the bytes the bench itself sent.
module tb_window_feeder;

    localparam int IMG = 28;
    localparam int KK  = 5;
    localparam int NW  = IMG - KK + 1;
    localparam int NP  = IMG * IMG;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic         start;
    logic [4:0]   x;
    logic [4:0]   y;
    logic [199:0] imgin;
    logic         win_valid;
    logic         win_ready;
    logic         frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    window_feeder #(.IMG_W(IMG), .K(KK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .start      (start),
        .x          (x),
        .y          (y),
        .imgin      (imgin),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int seed, input int k);
        case (seed)
            0:       return 8'(k % 256);
            1:       return 8'((k * 7 + 3) % 256);
            default: return 8'((255 - (k % 256)) ^ (k / 28));
        endcase
    endfunction

    // ---------------- reference model (negedge sampling) ----------------
    // phase: 0 loading, 1 window being gathered, 2 window presented
    logic [7:0] m_img [NP];
    int m_phase, m_ld, m_gap, m_win, m_accepts, m_starts;
    bit m_first, m_done_due;

    always @(negedge clk) begin
        logic [199:0] e;
        int ex, ey;
        if (!rst_n) begin
            m_phase    = 0;
            m_ld       = 0;
            m_gap      = 0;
            m_win      = 0;
            m_first    = 1'b0;
            m_done_due = 1'b0;
        end else begin
            if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) begin
                    m_phase = 2;
                    m_first = 1'b1;
                end
            end
            if (start) m_starts++;
            chk("m_pix_ready", pix_ready, m_phase == 0);
            chk("m_win_valid", win_valid, m_phase == 2);
            chk("m_frame_done", frame_done, m_done_due);
            m_done_due = 1'b0;
            chk("m_start", start, (m_phase == 2) && m_first && (m_win == 0));
            if (m_phase == 2) begin
                ex = m_win / NW;
                ey = m_win % NW;
                e  = '0;
                for (int i = 0; i < KK; i++) begin
                    for (int j = 0; j < KK; j++) begin
                        e[(i*KK+j)*8 +: 8] = m_img[(ex+i)*IMG + ey + j];
                    end
                end
                chk("m_x", x, ex);
                chk("m_y", y, ey);
                chk("m_imgin", imgin, e);
            end
            if (m_phase == 0 && pix_valid) begin
                m_img[m_ld] = pix_in;
                m_ld++;
                if (m_ld == NP) begin
                    m_ld    = 0;
                    m_phase = 1;
                    m_gap   = 26;
                end
            end else if (m_phase == 2 && win_ready) begin
                if (win_valid) m_accepts++;
                m_win++;
                if (m_win == NW * NW) begin
                    m_win      = 0;
                    m_phase    = 0;
                    m_done_due = 1'b1;
                end else begin
                    m_phase = 1;
                    m_gap   = 26;
                end
            end
            m_first = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_frame(input int seed, input bit gapped);
        int k = 0;
        int cyc = 0;
        while (k < NP && cyc < 4000) begin
            pix_valid = gapped ? (cyc % 3 != 2) : 1'b1;
            pix_in    = pix_valid ? pat(seed, k) : 8'hEE;
            @(posedge clk); #1;
            if (pix_valid) k++;
            cyc++;
        end
        pix_valid = 1'b0;
        pix_in    = 8'h00;
        chk("load_bytes", k, NP);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!win_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic take();
        win_ready = 1'b1;
        @(posedge clk); #1;
        win_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        n_checks++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rst_n     = 1'b0;
        pix_in    = 8'h00;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        m_accepts = 0;
        m_starts  = 0;

        @(posedge clk); #1;
        chk("rst_win_valid", win_valid, 0);
        chk("rst_start", start, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_imgin", imgin, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_pix_ready", pix_ready, 1);

        // frame 1: ramp, gapped valid
        load_frame(0, 1'b1);
        wait_valid(n);
        chk("f1_first_latency", n, 25);
        chk("f1_start", start, 1);
        chk("f1_x0", x, 0);
        chk("f1_y0", y, 0);
        chk("f1_b0", imgin[7:0], 8'h00);
        chk("f1_b4", imgin[39:32], 8'h04);
        chk("f1_b5", imgin[47:40], 8'h1C);
        chk("f1_b24", imgin[199:192], 8'h74);

        // backpressure with ignored pixel traffic
        pix_valid = 1'b1;
        pix_in    = 8'hEE;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_valid", win_valid, 1);
            chk("bp_start", start, 0);
            chk("bp_b24", imgin[199:192], 8'h74);
            chk("bp_pix_ready", pix_ready, 0);
        end
        take();
        chk("bp_drop", win_valid, 0);
        wait_valid(n);
        pix_valid = 1'b0;
        chk("w1_latency", n, 25);
        chk("w1_x", x, 0);
        chk("w1_y", y, 1);
        chk("w1_b0", imgin[7:0], 8'h01);

        for (int w = 1; w < NW * NW; w++) begin
            if (w > 1) begin
                wait_valid(n);
                chk("gather_latency", n, 25);
            end
            if (w == NW) begin
                chk("wrap_x", x, 1);
                chk("wrap_y", y, 0);
                chk("wrap_b0", imgin[7:0], 8'h1C);
                chk("wrap_b24", imgin[199:192], 8'h90);
            end
            if (w == NW * NW - 1) begin
                chk("last_x", x, 23);
                chk("last_y", y, 23);
                chk("last_b24", imgin[199:192], 8'h0F);
            end
            take();
        end
        chk("end_frame_done", frame_done, 1);
        chk("end_pix_ready", pix_ready, 1);
        chk("end_x", x, 0);
        chk("end_y", y, 0);
        @(posedge clk); #1;
        chk("end_frame_done_low", frame_done, 0);
        chk("end_windows", m_accepts, NW * NW);
        chk("end_starts", m_starts, 1);

        // frame 2: reset in the middle of gathering window (5,7)
        load_frame(1, 1'b0);
        for (int w = 0; w <= 5 * NW + 6; w++) begin
            wait_valid(n);
            chk("f2_latency", n, 25);
            take();
        end
        repeat (10) @(posedge clk);
        #1;
        chk("mid_valid", win_valid, 0);
        chk("mid_x", x, 5);
        chk("mid_y", y, 7);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", win_valid, 0);
        chk("arst_x", x, 0);
        chk("arst_y", y, 0);
        chk("arst_imgin", imgin, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_pix_ready", pix_ready, 1);

        // frame 3: fresh load after the abandoned frame
        load_frame(2, 1'b1);
        wait_valid(n);
        chk("f3_latency", n, 25);
        chk("f3_start", start, 1);
        chk("f3_x", x, 0);
        chk("f3_y", y, 0);
        chk("f3_b0", imgin[7:0], pat(2, 0));
        chk("f3_b24", imgin[199:192], pat(2, 4 * IMG + 4));
        for (int w = 0; w < 3; w++) begin
            take();
            wait_valid(n);
            chk("f3_next_latency", n, 25);
        end
        chk("f3_y3", y, 3);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
